// File: rtl/chorus_pkg.sv
// -----------------------------------------------------------------------------
// chorus_pkg
// Shared constants for the chorus LFO and the downstream chorus stage:
//   - default widths for the LFO phase accumulator and quarter-wave table
//   - modulation word width and its "zero deflection" offset-binary code
//   - quadrant encoding of the two phase MSBs
// -----------------------------------------------------------------------------
package chorus_pkg;

    localparam int DEF_PHASE_W = 24;  // phase accumulator width
    localparam int DEF_LUT_AW  = 6;   // quarter-wave table address width
    localparam int DEF_MAG_W   = 8;   // quarter-wave table magnitude width

    localparam int             MOD_W    = 9;
    localparam logic [MOD_W-1:0] MOD_ZERO = 9'd256;

    // Phase MSBs select the quadrant. Bit 0 mirrors the table address
    // (falling half of each lobe), bit 1 negates the magnitude.
    typedef enum logic [1:0] {
        QUAD_POS_RISE = 2'b00,
        QUAD_POS_FALL = 2'b01,
        QUAD_NEG_RISE = 2'b10,
        QUAD_NEG_FALL = 2'b11
    } quad_e;

    localparam int QUAD_MIRROR_BIT = 0;
    localparam int QUAD_NEGATE_BIT = 1;

    function automatic logic quad_mirror(input logic [1:0] quad);
        return quad[QUAD_MIRROR_BIT];
    endfunction

    function automatic logic quad_negate(input logic [1:0] quad);
        return quad[QUAD_NEGATE_BIT];
    endfunction

endpackage

// File: rtl/chorus_lfo_qrom.sv
// -----------------------------------------------------------------------------
// chorus_lfo_qrom
// 64 x 8 quarter-wave sine ROM with a registered read (one cycle latency).
// Entry i = round(255 * sin((i + 0.5) * pi / 128)), i = 0..63. The half-step
// offset keeps the table free of a zero entry and of duplicated full-scale
// entries at the quadrant seams, so mirroring never repeats a sample.
// Ports:
//   clk   in   system clock
//   addr  in   table index (already mirrored by the caller)
//   mag   out  unsigned magnitude, valid one cycle after addr
// -----------------------------------------------------------------------------
module chorus_lfo_qrom
    import chorus_pkg::*;
(
    input  logic                  clk,
    input  logic [DEF_LUT_AW-1:0] addr,
    output logic [DEF_MAG_W-1:0]  mag
);

    localparam logic [DEF_MAG_W-1:0] QROM [0:63] = '{
        8'd3,   8'd9,   8'd16,  8'd22,  8'd28,  8'd34,  8'd41,  8'd47,
        8'd53,  8'd59,  8'd65,  8'd71,  8'd77,  8'd83,  8'd89,  8'd95,
        8'd100, 8'd106, 8'd112, 8'd117, 8'd123, 8'd128, 8'd134, 8'd139,
        8'd144, 8'd149, 8'd154, 8'd159, 8'd164, 8'd169, 8'd174, 8'd178,
        8'd183, 8'd187, 8'd191, 8'd195, 8'd199, 8'd203, 8'd207, 8'd210,
        8'd214, 8'd217, 8'd220, 8'd223, 8'd226, 8'd229, 8'd232, 8'd234,
        8'd237, 8'd239, 8'd241, 8'd243, 8'd245, 8'd247, 8'd248, 8'd249,
        8'd251, 8'd252, 8'd253, 8'd253, 8'd254, 8'd255, 8'd255, 8'd255
    };

    logic [DEF_MAG_W-1:0] mag_q;

    always_ff @(posedge clk) begin
        mag_q <= QROM[addr];
    end

    assign mag = mag_q;

endmodule

// File: rtl/chorus_lfo.sv
// -----------------------------------------------------------------------------
// chorus_lfo
// Low-frequency sine oscillator feeding the chorus stage's sin_mod input.
// A phase accumulator advances by inc_q on every sample_tick; the phase is
// turned into a sine sample through a quarter-wave table, scaled by depth and
// emitted as offset-binary (256 = no deflection) with a one-cycle mod_valid.
// Four-stage pipeline, tick to mod_valid = 4 cycles, accepts a tick per cycle.
//
// Optional build macro: CHORUS_LFO_TRIANGLE_EN adds wave_sel; when 1 the
// table magnitude is replaced by a linear ramp of the mirrored address.
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   sample_tick  in   audio sample strobe, launches one output sample
//   rate_inc     in   phase increment, captured on rate_load
//   rate_load    in   strobe loading rate_inc (next tick onwards)
//   depth        in   modulation depth 0..255, sampled at the output stage
//   phase_sync   in   strobe clearing the phase (wins over the increment)
//   wave_sel     in   (macro only) 1 = triangle, 0 = sine
//   sin_mod      out  offset-binary modulation value, 1..510
//   mod_valid    out  one-cycle pulse when sin_mod updates
// -----------------------------------------------------------------------------
module chorus_lfo
    import chorus_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int LUT_AW  = DEF_LUT_AW,
    parameter int MAG_W   = DEF_MAG_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_tick,
    input  logic [PHASE_W-1:0] rate_inc,
    input  logic               rate_load,
    input  logic [7:0]         depth,
    input  logic               phase_sync,
`ifdef CHORUS_LFO_TRIANGLE_EN
    input  logic               wave_sel,
`endif
    output logic [MOD_W-1:0]   sin_mod,
    output logic               mod_valid
);

    // Accumulator and increment
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] inc_q, inc_d;

    // S1: quadrant and raw table address
    logic              v1_q;
    quad_e             quad1_q;
    logic [LUT_AW-1:0] addr1_q;

    // S2: mirrored address and sign
    logic              v2_q;
    logic              neg2_q;
    logic [LUT_AW-1:0] addr2_q;

    // S3: table read
    logic              v3_q;
    logic              neg3_q;
    logic [MAG_W-1:0]  rom_mag;
    logic [MAG_W-1:0]  mag3;

    // S4: output
    logic [MOD_W-1:0]  sin_mod_q, sin_mod_d;
    logic              valid_q;

    // Output arithmetic
    logic signed [MOD_W-1:0] mag_ext;
    logic signed [MOD_W-1:0] s_val;
    logic signed [MOD_W-1:0] depth_s;
    logic signed [17:0]      prod;
    logic signed [17:0]      prod_sh;
    logic        [17:0]      sum;
    logic                    unused_bits;

    always_comb begin
        inc_d   = rate_load ? rate_inc : inc_q;
        phase_d = phase_q;
        if (phase_sync) begin
            phase_d = '0;
        end else if (sample_tick) begin
            // The tick uses the increment held before any same-cycle load.
            phase_d = phase_q + inc_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= '0;
            inc_q     <= '0;
            v1_q      <= 1'b0;
            quad1_q   <= QUAD_POS_RISE;
            addr1_q   <= '0;
            v2_q      <= 1'b0;
            neg2_q    <= 1'b0;
            addr2_q   <= '0;
            v3_q      <= 1'b0;
            neg3_q    <= 1'b0;
            sin_mod_q <= MOD_ZERO;
            valid_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            inc_q   <= inc_d;

            v1_q <= sample_tick;
            if (sample_tick) begin
                quad1_q <= quad_e'(phase_d[PHASE_W-1 -: 2]);
                addr1_q <= phase_d[PHASE_W-3 -: LUT_AW];
            end

            v2_q    <= v1_q;
            neg2_q  <= quad_negate(quad1_q);
            addr2_q <= quad_mirror(quad1_q) ? ~addr1_q : addr1_q;

            v3_q   <= v2_q;
            neg3_q <= neg2_q;

            sin_mod_q <= sin_mod_d;
            valid_q   <= v3_q;
        end
    end

    chorus_lfo_qrom u_qrom (
        .clk  (clk),
        .addr (addr2_q),
        .mag  (rom_mag)
    );

`ifdef CHORUS_LFO_TRIANGLE_EN
    // Waveform select travels alongside the sample; the ramp is registered so
    // it lines up with the ROM's read latency.
    logic             sel1_q, sel2_q, sel3_q;
    logic [MAG_W-1:0] ramp3_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel1_q  <= 1'b0;
            sel2_q  <= 1'b0;
            sel3_q  <= 1'b0;
            ramp3_q <= '0;
        end else begin
            if (sample_tick) begin
                sel1_q <= wave_sel;
            end
            sel2_q  <= sel1_q;
            sel3_q  <= sel2_q;
            // Replicate the address MSBs into the low bits so 63 maps to 255.
            ramp3_q <= {addr2_q, addr2_q[LUT_AW-1 -: MAG_W-LUT_AW]};
        end
    end

    assign mag3 = sel3_q ? ramp3_q : rom_mag;
`else
    assign mag3 = rom_mag;
`endif

    always_comb begin
        mag_ext   = $signed({1'b0, mag3});
        s_val     = neg3_q ? -mag_ext : mag_ext;
        depth_s   = $signed({1'b0, depth});
        prod      = 18'(s_val) * 18'(depth_s);
        // Arithmetic shift floors toward minus infinity, so the result spans
        // -255..254 and the offset sum stays inside 1..510.
        prod_sh   = prod >>> 8;
        sum       = 18'(prod_sh) + 18'(MOD_ZERO);
        sin_mod_d = v3_q ? sum[MOD_W-1:0] : sin_mod_q;
    end

    assign unused_bits = &{1'b0, sum[17:MOD_W]};

    assign sin_mod   = sin_mod_q;
    assign mod_valid = valid_q;

endmodule

// File: doc/chorus_lfo.md
Name: chorus_lfo

Overview:
- Low-frequency sine oscillator that drives the chorus effect's 9-bit `sin_mod` modulation input.
- Sits directly upstream of the chorus stage in the audio loopback effects chain.
- Advances a phase accumulator once per audio sample strobe and looks up a quarter-wave sine table.
- Scales the result by a depth control and presents it as offset-binary `sin_mod`, with a one-cycle `mod_valid` pulse.

Parameters:
- PHASE_W, 24: phase accumulator width; the top 2 bits are the quadrant.
- LUT_AW, 6: quarter-wave table address width (64 entries); these are the phase bits just below the quadrant.
- MAG_W, 8: table magnitude width, unsigned.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-cycle strobe at the audio sample rate
- rate_inc  in  PHASE_W  phase increment per tick
- rate_load  in  1  strobe; captures rate_inc into the active increment register
- depth  in  8  modulation depth, 0..255 (255 is approximately full scale)
- phase_sync  in  1  strobe; forces phase to 0
- sin_mod  out  9  offset-binary modulation value; 256 means zero deflection
- mod_valid  out  1  one-cycle pulse when sin_mod updates

Behaviour:
- Reset (asynchronous, on reset_n low):
  - phase = 0 and active increment inc_r = 0.
  - sin_mod = 9'd256, mod_valid = 0, all pipeline valid bits = 0.
  - Reset mid-operation discards in-flight samples; no mod_valid pulse is emitted for them.
- Increment register:
  - On rate_load, inc_r <= rate_inc.
  - A sample_tick in the same cycle uses the old inc_r; the new value applies from the next tick.
- Phase update at a tick: phase_n = phase + inc_r, modulo 2^PHASE_W with natural wrap.
  - If phase_sync is asserted, phase_n = 0; sync has priority over the increment.
  - A phase_sync without a tick clears phase and launches no sample.
- Pipeline: fully pipelined; back-to-back ticks are legal; no backpressure. Latency from a tick to mod_valid is 4 cycles.
  - S1 (tick edge): phase <= phase_n. Capture q = phase_n[PHASE_W-1:PHASE_W-2] and a = phase_n[PHASE_W-3 -: LUT_AW].
  - S2: address = q[0] ? ~a : a (mirror in quadrants 1 and 3). Negate flag = q[1].
  - S3: registered ROM read: mag = round(255*sin((i+0.5)*pi/128)) for i = 0..63. The "+0.5" offset avoids zero and full-scale duplicates.
  - S4: s = negate ? -mag : mag, a 9-bit signed value in -255..255. prod = s*depth (17-bit signed). scaled = prod >>> 8 (arithmetic shift, floor). sin_mod <= scaled + 256, range 1..510, never wraps. mod_valid <= 1 for exactly one cycle.
- Depth: sampled at S4, so a depth change takes effect on the next emitted value. depth = 0 gives sin_mod = 256.
- Between pulses, sin_mod holds its last value.

Optional Feature:
- Macro: CHORUS_LFO_TRIANGLE_EN
- Defined:
  - Adds input port `wave_sel` (1 bit), sampled at S1 and carried down the pipeline.
  - When wave_sel = 1, S3 bypasses the ROM: mag = {addr, addr[LUT_AW-1 -: MAG_W-LUT_AW]} (linear ramp 0..255 from the mirrored address).
  - Sign, depth scaling, offset and latency are identical to the sine path.
- Undefined: no wave_sel port; sine only; no ramp logic synthesized.

Decomposition:
- Package chorus_pkg holds:
  - PHASE_W, LUT_AW, MAG_W defaults.
  - MOD_W = 9 and MOD_ZERO = 9'd256, which the chorus stage also consumes.
  - The quadrant encoding constants.
- Sub-module chorus_lfo_qrom: 64x8 registered quarter-wave ROM (clk, addr in, mag out), generated from the formula above.

Test Plan:
- Reset with no ticks: sin_mod = 256 and mod_valid = 0 for 100 cycles. Reset mid-stream with ticks in flight: no mod_valid within 4 cycles after release.
- depth = 255, rate_load with rate_inc = 2^22, then 4 ticks spaced 8 cycles apart: sin_mod sequence 510, 253, 1, 258, each with a mod_valid pulse exactly 4 cycles after its tick.
- Same setup with depth = 0: every pulse gives sin_mod = 256. Then depth = 128 at phase 2^22: sin_mod = 256 + (255*128 >>> 8) = 383.
- rate_load (rate_inc = 2^22) coincident with the first tick while inc_r = 0: the first output is 258 (phase 0); the second tick gives 510.
- Back-to-back ticks for 8 cycles: 8 consecutive mod_valid pulses. phase_sync coincident with a tick: the output equals the phase-0 value, 258 at depth 255.
- CHORUS_LFO_TRIANGLE_EN defined, wave_sel = 1, depth = 255, rate_inc = 2^22: outputs 510, 256, 1, 256, with the same 4-cycle latency.
